// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-8 demultiplexer.
// Lane count is fixed at eight, so the select is always three bits wide.
package demux_pkg;

    localparam int N_OUT = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_sel_decoder.sv
// 3-to-8 one-hot decoder; purely combinational, zero latency.
// No flow control: the output follows sel directly.
module demux_sel_decoder
    import demux_pkg::*;
(
    input  sel_t             sel,
    output logic [N_OUT-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/demux_1x8.sv
// Registered 1-to-8 demux: data_in lands on lane[sel] and every other lane is zero. Latency is 1 cycle.
// No backpressure: the block is always live and re-registers its output on every edge.
module demux_1x8
    import demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       data_in,
    input  sel_t                    sel,
    output logic [N_OUT*DATA_W-1:0] data_out
);

    logic [N_OUT-1:0]             w_onehot;
    logic [N_OUT-1:0][DATA_W-1:0] w_next;
    logic [N_OUT-1:0][DATA_W-1:0] r_lanes;

    demux_sel_decoder u_dec (
        .sel    (sel),
        .onehot (w_onehot)
    );

    always_comb begin
        w_next = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_next[k] = w_onehot[k] ? data_in : '0;
        end
    end

    // The old lane clears and the new lane loads on the same edge, so two lanes are never set at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lanes <= '0;
        end else begin
            r_lanes <= w_next;
        end
    end

    // In the packed array, lane k occupies bits [k*DATA_W +: DATA_W].
    assign data_out = r_lanes;

endmodule

// File: tb/tb_demux_1x8.sv
// Directed scoreboard bench for demux_1x8 at DATA_W=1 and DATA_W=4.
module tb_demux_1x8;
    import demux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n = 1'b0;
    logic        d1     = 1'b0;
    sel_t        s1     = '0;
    logic [7:0]  o1;

    logic        rst4_n = 1'b0;
    logic [3:0]  d4     = '0;
    sel_t        s4     = '0;
    logic [31:0] o4;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    demux_1x8 #(.DATA_W(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst1_n),
        .data_in  (d1),
        .sel      (s1),
        .data_out (o1)
    );

    demux_1x8 #(.DATA_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst4_n),
        .data_in  (d4),
        .sel      (s4),
        .data_out (o4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge, are sampled on the next edge, and are checked 1 time unit later.
    task automatic step1(input string tag, input logic r, input logic d, input sel_t s,
                         input logic [7:0] e);
        string       t;
        logic [31:0] x;
        rst1_n = r;
        d1     = d;
        s1     = s;
        exp_q.push_back({24'h0, e});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        t = tag_q.pop_front();
        x = exp_q.pop_front();
        chk(t, {24'h0, o1}, x);
        checks++;
        assert ($countones(o1) <= 1) else begin
            errors++;
            $error("FAIL %s_onehot observed=%h expected=at_most_one_lane", tag, o1);
        end
    endtask

    task automatic step4(input string tag, input logic r, input logic [3:0] d, input sel_t s,
                         input logic [31:0] e);
        string       t;
        logic [31:0] x;
        rst4_n = r;
        d4     = d;
        s4     = s;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        t = tag_q.pop_front();
        x = exp_q.pop_front();
        chk(t, o4, x);
    endtask

    initial begin
        #1;
        // Reset must win over the live data_in and sel values.
        step1("reset0", 1'b0, 1'b1, 3'd5, 8'h00);
        step1("reset1", 1'b0, 1'b1, 3'd5, 8'h00);

        for (int i = 0; i < 8; i++) begin
            step1("walk_one", 1'b1, 1'b1, sel_t'(i), 8'(1 << i));
        end
        for (int i = 0; i < 8; i++) begin
            step1("walk_zero", 1'b1, 1'b0, sel_t'(i), 8'h00);
        end

        step1("switch_a", 1'b1, 1'b1, 3'd3, 8'h08);
        step1("switch_b", 1'b1, 1'b1, 3'd6, 8'h40);
        step1("hold_a",   1'b1, 1'b1, 3'd6, 8'h40);

        step1("mid_pre",  1'b1, 1'b1, 3'd7, 8'h80);
        step1("mid_rst",  1'b0, 1'b1, 3'd7, 8'h00);
        step1("mid_post", 1'b1, 1'b1, 3'd7, 8'h80);

        step4("w4_reset0", 1'b0, 4'hA, 3'd2, 32'h0000_0000);
        step4("w4_reset1", 1'b0, 4'hA, 3'd2, 32'h0000_0000);
        step4("w4_sel2",   1'b1, 4'hA, 3'd2, 32'h0000_0A00);
        step4("w4_sel0",   1'b1, 4'hA, 3'd0, 32'h0000_000A);
        step4("w4_sel7",   1'b1, 4'h5, 3'd7, 32'h5000_0000);
        step4("w4_sel4",   1'b1, 4'hF, 3'd4, 32'h000F_0000);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
